// File: rtl/noc_pkt_pkg.sv
// Shared NoC packet header definitions, used by the packetizer and by the router-side decode.
// Field widths depend on each instance's mesh parameters, so they are passed in at the call site.
package noc_pkt_pkg;

  localparam int unsigned HDR_FIELD_W = 16;
  localparam int unsigned HDR_MAX_W   = 64;

  typedef logic [HDR_MAX_W-1:0] hdr_word_t;

  typedef struct packed {
    logic [HDR_FIELD_W-1:0] len;
    logic [HDR_FIELD_W-1:0] src_y;
    logic [HDR_FIELD_W-1:0] src_x;
    logic [HDR_FIELD_W-1:0] dest_y;
    logic [HDR_FIELD_W-1:0] dest_x;
  } hdr_fields_t;

  function automatic int unsigned hdr_width(input int unsigned x_w, input int unsigned y_w,
                                            input int unsigned len_w);
    return 2 * x_w + 2 * y_w + len_w;
  endfunction

  function automatic hdr_word_t field_mask(input int unsigned w);
    return (hdr_word_t'(1) << w) - hdr_word_t'(1);
  endfunction

  // LSB first: dest_x, dest_y, src_x, src_y, len; everything above is zero.
  function automatic hdr_word_t pack_header(input hdr_fields_t f, input int unsigned x_w,
                                            input int unsigned y_w, input int unsigned len_w);
    hdr_word_t   h;
    int unsigned pos;
    h   = '0;
    pos = 0;
    h   = h | ((hdr_word_t'(f.dest_x) & field_mask(x_w)) << pos);
    pos = pos + x_w;
    h   = h | ((hdr_word_t'(f.dest_y) & field_mask(y_w)) << pos);
    pos = pos + y_w;
    h   = h | ((hdr_word_t'(f.src_x) & field_mask(x_w)) << pos);
    pos = pos + x_w;
    h   = h | ((hdr_word_t'(f.src_y) & field_mask(y_w)) << pos);
    pos = pos + y_w;
    h   = h | ((hdr_word_t'(f.len) & field_mask(len_w)) << pos);
    return h;
  endfunction

  function automatic hdr_fields_t unpack_header(input hdr_word_t h, input int unsigned x_w,
                                                input int unsigned y_w, input int unsigned len_w);
    hdr_fields_t f;
    int unsigned pos;
    pos      = 0;
    f.dest_x = HDR_FIELD_W'((h >> pos) & field_mask(x_w));
    pos      = pos + x_w;
    f.dest_y = HDR_FIELD_W'((h >> pos) & field_mask(y_w));
    pos      = pos + y_w;
    f.src_x  = HDR_FIELD_W'((h >> pos) & field_mask(x_w));
    pos      = pos + x_w;
    f.src_y  = HDR_FIELD_W'((h >> pos) & field_mask(y_w));
    pos      = pos + y_w;
    f.len    = HDR_FIELD_W'((h >> pos) & field_mask(len_w));
    return f;
  endfunction

endpackage

// File: rtl/axis_packetizer.sv
// Wraps a payload AXI-Stream into NoC packets: one header beat, then cmd_len payload beats.
// state   | meaning
// IDLE    | waiting for a command; header (or header-only packet) is loaded from here
// PAYLOAD | forwarding payload beats until the remaining count reaches zero
module axis_packetizer
  import noc_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_ROUTERS_X = 4,
  parameter int unsigned MAX_ROUTERS_Y = 4,
  parameter int unsigned ROUTER_X      = 0,
  parameter int unsigned ROUTER_Y      = 0,
  parameter int unsigned MAX_PACKAGES  = 4,
  localparam int unsigned X_W   = $clog2(MAX_ROUTERS_X),
  localparam int unsigned Y_W   = $clog2(MAX_ROUTERS_Y),
  localparam int unsigned LEN_W = $clog2(MAX_PACKAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_W-1:0]        cmd_dest_x,
  input  logic [Y_W-1:0]        cmd_dest_y,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  err
);

  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_PAYLOAD = 1'b1;
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_PACKAGES);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  logic [0:0]            state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;
  logic                  err_q, err_d;

  logic                  slot_free;
  logic                  cmd_fire;
  logic                  beat_fire;
  hdr_fields_t           hdr_f;
  logic [DATA_WIDTH-1:0] hdr_word;

  assign slot_free = !tvalid_q || m_tready;
  assign cmd_ready = (state_q == S_IDLE) && slot_free;
  assign s_tready  = (state_q == S_PAYLOAD) && slot_free;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat_fire = s_tvalid && s_tready;

  always_comb begin
    hdr_f        = '0;
    hdr_f.dest_x = HDR_FIELD_W'(cmd_dest_x);
    hdr_f.dest_y = HDR_FIELD_W'(cmd_dest_y);
    hdr_f.src_x  = HDR_FIELD_W'(ROUTER_X);
    hdr_f.src_y  = HDR_FIELD_W'(ROUTER_Y);
    hdr_f.len    = HDR_FIELD_W'(cmd_len);
    hdr_word     = DATA_WIDTH'(pack_header(hdr_f, X_W, Y_W, LEN_W));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    err_d    = 1'b0;
    // A free slot with nothing new to load means the held beat has been taken.
    if (slot_free) begin
      tvalid_d = 1'b0;
    end
    if (cmd_fire) begin
      if (cmd_len > MAX_LEN) begin
        err_d = 1'b1;
      end else begin
        tdata_d  = hdr_word;
        tlast_d  = (cmd_len == '0);
        tvalid_d = 1'b1;
        cnt_d    = cmd_len;
        state_d  = (cmd_len == '0) ? S_IDLE : S_PAYLOAD;
      end
    end else if (beat_fire) begin
      tdata_d  = s_tdata;
      tlast_d  = (cnt_q == ONE);
      tvalid_d = 1'b1;
      cnt_d    = cnt_q - ONE;
      if (cnt_q == ONE) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      err_q    <= err_d;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;
  assign m_tvalid = tvalid_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_axis_packetizer.sv
// Bench for axis_packetizer: directed packet scenarios, then randomized packets with stalls
// on both sides checked against a queue-based packet model.
module tb_axis_packetizer;

  localparam int unsigned RX = 1;
  localparam int unsigned RY = 2;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_dest_x, cmd_dest_y;
  logic [2:0]  cmd_len;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        busy, err;

  logic        c2_valid, c2_ready;
  logic [1:0]  c2_dx, c2_dy;
  logic [2:0]  c2_len;
  logic        s2_tready, m2_tvalid, m2_tlast, busy2, err2;
  logic [31:0] m2_tdata;

  int checks = 0;
  int errors = 0;

  axis_packetizer #(
    .DATA_WIDTH(32), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
    .ROUTER_X(RX), .ROUTER_Y(RY), .MAX_PACKAGES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest_x(cmd_dest_x), .cmd_dest_y(cmd_dest_y), .cmd_len(cmd_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .err(err)
  );

  // Second node at (1,0), used for the header-only packet.
  axis_packetizer #(
    .DATA_WIDTH(32), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
    .ROUTER_X(1), .ROUTER_Y(0), .MAX_PACKAGES(4)
  ) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_dest_x(c2_dx), .cmd_dest_y(c2_dy), .cmd_len(c2_len),
    .s_tdata(32'h0), .s_tvalid(1'b0), .s_tready(s2_tready),
    .m_tdata(m2_tdata), .m_tvalid(m2_tvalid), .m_tready(1'b1), .m_tlast(m2_tlast),
    .busy(busy2), .err(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Header value from field placement: 2 bits dest_x, 2 dest_y, 2 src_x, 2 src_y, 3 len.
  function automatic logic [31:0] hdr_exp(input int dx, input int dy, input int sx,
                                          input int sy, input int len);
    return 32'(dx + 4 * dy + 16 * sx + 64 * sy + 256 * len);
  endfunction

  logic [32:0] exp_q[$];
  logic [32:0] e;
  int          remaining;
  int          pkts;
  int          cyc;
  bit          err_pending, err_next;

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_dest_x = 0; cmd_dest_y = 0; cmd_len = 0;
    s_tdata = 0; s_tvalid = 0; m_tready = 0;
    c2_valid = 0; c2_dx = 0; c2_dy = 0; c2_len = 0;
    step(); step();

    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_s_tready", s_tready, 0);
    rst = 1'b0;
    m_tready = 1'b1;
    #1;
    check("idle_cmd_ready", cmd_ready, 1);

    // Basic two-beat packet with the sink always ready.
    cmd_valid = 1; cmd_dest_x = 3; cmd_dest_y = 0; cmd_len = 2;
    step();
    cmd_valid = 0;
    check("p1_hdr", m_tdata, 32'h0000_0293);
    check("p1_hdr_valid", m_tvalid, 1);
    check("p1_hdr_last", m_tlast, 0);
    check("p1_busy", busy, 1);
    check("p1_no_cmd_ready", cmd_ready, 0);
    s_tvalid = 1; s_tdata = 32'hA5A5_0001;
    #1;
    check("p1_s_tready", s_tready, 1);
    step();
    check("p1_beat1", {m_tlast, m_tdata}, {1'b0, 32'hA5A5_0001});
    s_tdata = 32'hA5A5_0002;
    step();
    check("p1_beat2", {m_tlast, m_tdata}, {1'b1, 32'hA5A5_0002});
    check("p1_busy_done", busy, 0);
    s_tvalid = 0;
    step();
    check("p1_drained", m_tvalid, 0);

    // Same packet, sink stalled three cycles on each beat.
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    m_tready = 0; s_tvalid = 1; s_tdata = 32'hA5A5_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("p2_hold_hdr", {m_tvalid, m_tlast, m_tdata}, {2'b10, 32'h0000_0293});
      check("p2_stall_s_tready", s_tready, 0);
      step();
    end
    m_tready = 1;
    #1;
    check("p2_resume_s_tready", s_tready, 1);
    step();
    m_tready = 0; s_tdata = 32'hA5A5_0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("p2_hold_b1", {m_tvalid, m_tlast, m_tdata}, {2'b10, 32'hA5A5_0001});
      check("p2_stall_s_tready", s_tready, 0);
      step();
    end
    m_tready = 1;
    step();
    s_tvalid = 0; m_tready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("p2_hold_b2", {m_tvalid, m_tlast, m_tdata}, {2'b11, 32'hA5A5_0002});
      step();
    end
    m_tready = 1;
    step();
    check("p2_drained", m_tvalid, 0);

    // Header-only packet on the (1,0) node.
    c2_valid = 1; c2_dx = 2; c2_dy = 1; c2_len = 0;
    #1;
    check("p3_cmd_ready", c2_ready, 1);
    step();
    c2_valid = 0;
    check("p3_hdr", {m2_tvalid, m2_tlast, m2_tdata}, {2'b11, 32'h0000_0016});
    check("p3_idle", busy2, 0);
    step();
    check("p3_single_beat", m2_tvalid, 0);

    // Oversized command is rejected with a one-cycle err pulse.
    cmd_valid = 1; cmd_dest_x = 1; cmd_dest_y = 2; cmd_len = 5;
    #1;
    check("p4_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 0;
    check("p4_err", err, 1);
    check("p4_no_valid", m_tvalid, 0);
    check("p4_idle", busy, 0);
    step();
    check("p4_err_cleared", err, 0);
    check("p4_still_no_valid", m_tvalid, 0);

    // Reset in the middle of a four-beat packet.
    cmd_valid = 1; cmd_dest_x = 1; cmd_dest_y = 1; cmd_len = 4;
    step();
    cmd_valid = 0;
    check("p5_hdr", m_tdata, hdr_exp(1, 1, RX, RY, 4));
    s_tvalid = 1; s_tdata = 32'hCAFE_0001;
    step();
    rst = 1; s_tvalid = 0;
    step();
    check("p5_rst_valid", m_tvalid, 0);
    check("p5_rst_busy", busy, 0);
    check("p5_rst_last", m_tlast, 0);
    rst = 0;
    #1;
    check("p5_cmd_ready", cmd_ready, 1);
    step();
    check("p5_no_stale", m_tvalid, 0);
    cmd_valid = 1; cmd_dest_x = 2; cmd_dest_y = 3; cmd_len = 1;
    step();
    cmd_valid = 0;
    check("p5_next_hdr", {m_tvalid, m_tlast, m_tdata}, {2'b10, 32'h0000_019E});
    s_tvalid = 1; s_tdata = 32'h1234_5678;
    step();
    s_tvalid = 0;
    check("p5_next_beat", {m_tvalid, m_tlast, m_tdata}, {2'b11, 32'h1234_5678});
    step();
    check("p5_next_drained", m_tvalid, 0);

    // Random back-to-back packets with stalls on both sides.
    remaining = 0; pkts = 0; cyc = 0; err_pending = 0;
    while ((pkts < 100 || remaining > 0 || exp_q.size() > 0) && cyc < 20000) begin
      cmd_valid  = (pkts < 100) ? ($urandom_range(0, 1) == 1) : 1'b0;
      cmd_dest_x = 2'($urandom_range(0, 3));
      cmd_dest_y = 2'($urandom_range(0, 3));
      cmd_len    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                               : 3'($urandom_range(0, 4));
      s_tvalid   = ($urandom_range(0, 9) < 7);
      s_tdata    = $urandom;
      m_tready   = ($urandom_range(0, 9) < 7);
      #1;
      check("rnd_err", err, err_pending);
      check("rnd_busy", busy, remaining > 0);
      if (remaining > 0) check("rnd_no_cmd_ready", cmd_ready, 0);
      else check("rnd_no_s_tready", s_tready, 0);
      err_next = 0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_beat", {m_tlast, m_tdata}, 33'h0);
          check("rnd_unexpected_valid", m_tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_beat", {m_tlast, m_tdata}, e);
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_len > 4) begin
          err_next = 1;
        end else begin
          exp_q.push_back({cmd_len == 0, hdr_exp(cmd_dest_x, cmd_dest_y, RX, RY, cmd_len)});
          remaining = cmd_len;
          pkts++;
        end
      end
      if (s_tvalid && s_tready && remaining > 0) begin
        exp_q.push_back({remaining == 1, s_tdata});
        remaining--;
      end
      err_pending = err_next;
      step();
      cyc++;
    end
    check("rnd_all_packets", pkts, 100);
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_final_idle", {busy, m_tvalid}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning TDATA width in bits (>= header width, REQ-020).
REQ-002 SHALL have parameter MAX_ROUTERS_X, default 4, meaning mesh width; X_W = $clog2(MAX_ROUTERS_X).
REQ-003 SHALL have parameter MAX_ROUTERS_Y, default 4, meaning mesh height; Y_W = $clog2(MAX_ROUTERS_Y).
REQ-004 SHALL have parameter ROUTER_X, default 0, meaning this node's X coordinate, inserted as source.
REQ-005 SHALL have parameter ROUTER_Y, default 0, meaning this node's Y coordinate, inserted as source.
REQ-006 SHALL have parameter MAX_PACKAGES, default 4, meaning max payload beats per packet; LEN_W = $clog2(MAX_PACKAGES+1).
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-008 cmd_valid input 1, packet request; cmd_ready output 1, request accepted.
REQ-009 cmd_dest_x input X_W, cmd_dest_y input Y_W, destination router; cmd_len input LEN_W, payload beat count.
REQ-010 s_tdata input DATA_WIDTH, s_tvalid input 1, s_tready output 1, payload stream (slave).
REQ-011 m_tdata output DATA_WIDTH, m_tvalid output 1, m_tready input 1, m_tlast output 1, packet stream to router input channel (master).
REQ-012 busy output 1, high while not IDLE; err output 1, one-cycle pulse on rejected command.

Function
REQ-013 SHALL implement FSM with states IDLE and PAYLOAD, plus a registered output stage (m_tdata, m_tlast, m_tvalid).
REQ-014 Output slot free = !m_tvalid || m_tready; the registered stage loads only when free; while m_tvalid && !m_tready, m_tdata/m_tlast SHALL hold stable.
REQ-015 cmd_ready = (state==IDLE) && slot free, combinational.
REQ-016 On cmd handshake with 1 <= cmd_len <= MAX_PACKAGES: header loaded into output stage (m_tvalid=1 next cycle, m_tlast=0), remaining counter = cmd_len, state -> PAYLOAD.
REQ-017 On cmd handshake with cmd_len == 0: header loaded with m_tlast=1, state stays IDLE (header-only packet).
REQ-018 On cmd handshake with cmd_len > MAX_PACKAGES: nothing loaded, err=1 next cycle for one cycle, state stays IDLE.
REQ-019 PAYLOAD: s_tready = slot free; each s_tvalid&&s_tready loads s_tdata, decrements counter; beat with counter==1 sets m_tlast=1 and state -> IDLE.
REQ-020 Header: [X_W-1:0]=dest_x, [X_W+Y_W-1:X_W]=dest_y, next X_W bits=ROUTER_X, next Y_W bits=ROUTER_Y, next LEN_W bits=len, remaining upper bits 0.
REQ-021 s_tready SHALL be 0 in IDLE; cmd_ready SHALL be 0 in PAYLOAD (no overlap of packets).
REQ-022 Latency: cmd handshake at edge N -> header on m_* at N+1; payload beat accepted at edge M -> on m_* at M+1; one idle cmd_ready cycle minimum between packets is permitted.
REQ-023 Full throughput: with m_tready=1 and s_tvalid=1, one payload beat per cycle, no bubbles.

Reset
REQ-024 While rst=1 at a rising edge: state=IDLE, counter=0, m_tvalid=0, m_tlast=0, m_tdata=0, err=0, busy=0.
REQ-025 Reset mid-packet SHALL abandon the packet; no TLAST is generated for it and no stale beat emerges after reset.

Structure
REQ-026 Header field widths, header-packing function and header typedef SHALL live in shared package noc_pkt_pkg, also used by router-side decode.
REQ-027 No sub-module required; output stage and FSM are in-module.

Verification
REQ-028 ROUTER_X=1, ROUTER_Y=2, cmd dest(3,0) len=2, payload 0xA5A50001, 0xA5A50002, m_tready=1 -> m_tdata 0x00000293, 0xA5A50001, 0xA5A50002, m_tlast only on third beat.
REQ-029 Same packet, m_tready low for 3 cycles on each beat -> each beat held stable, no loss or duplication, s_tready low while stalled.
REQ-030 cmd len=0 dest(2,1) -> single beat 0x00000016 with m_tlast=1; state stays IDLE.
REQ-031 cmd len=5 -> cmd_ready=1, no m_tvalid, err pulses exactly one cycle.
REQ-032 rst asserted after header of a len=4 packet sent -> m_tvalid=0 next cycle, cmd_ready=1 after rst deasserts, next packet correct.
REQ-033 Back-to-back 100 random packets, random stalls on both sides -> scoreboard matches header fields, beat counts and TLAST placement.
